// File: rtl/juggle_pkg.sv
// Shared widths, frame record and scheduler state encoding for the juggling pattern evaluator path.
// Pure declarations: no latency, no flow control.
package juggle_pkg;

  localparam int MAX_BALLS = 7;
  localparam int NB_W      = 3;
  localparam int X_W       = 11;
  localparam int Y_W       = 10;
  localparam int ERR_W     = 15;

  localparam logic signed [ERR_W-1:0] TIMEOUT_ERR = 15'sh3FFF;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LAUNCH,
    WAIT,
    REPORT
  } sched_state_t;

  typedef struct packed {
    logic [NB_W-1:0]                 num_balls;
    logic [MAX_BALLS-1:0][X_W-1:0]   model_x;
    logic [MAX_BALLS-1:0][Y_W-1:0]   model_y;
    logic [MAX_BALLS-1:0][X_W-1:0]   real_x;
    logic [MAX_BALLS-1:0][Y_W-1:0]   real_y;
  } frame_t;

endpackage

// File: rtl/pattern_eval_scheduler_if.sv
// Frame input, evaluator handshake and result/statistics bundle of the scheduler.
// Wiring only: no latency; frames are pulses with no ready, the evaluator side is valid/done.
interface pattern_eval_scheduler_if;
  import juggle_pkg::*;

  logic                               frame_valid_in;
  logic [NB_W-1:0]                    num_balls_in;
  logic [MAX_BALLS-1:0][X_W-1:0]      model_x_in;
  logic [MAX_BALLS-1:0][Y_W-1:0]      model_y_in;
  logic [MAX_BALLS-1:0][X_W-1:0]      real_x_in;
  logic [MAX_BALLS-1:0][Y_W-1:0]      real_y_in;

  logic                               eval_rst_out;
  logic                               eval_valid_out;
  logic [NB_W-1:0]                    eval_num_balls_out;
  logic [MAX_BALLS-1:0][X_W-1:0]      eval_model_x_out;
  logic [MAX_BALLS-1:0][Y_W-1:0]      eval_model_y_out;
  logic [MAX_BALLS-1:0][X_W-1:0]      eval_real_x_out;
  logic [MAX_BALLS-1:0][Y_W-1:0]      eval_real_y_out;
  logic                               eval_done_in;
  logic signed [ERR_W-1:0]            eval_error_in;
  logic                               eval_correct_in;

  logic                               result_valid_out;
  logic signed [ERR_W-1:0]            result_error_out;
  logic                               result_correct_out;
  logic [7:0]                         streak_out;
  logic [15:0]                        frames_evaluated_out;
  logic [15:0]                        frames_dropped_out;
  logic                               timeout_out;
  logic                               busy_out;

  modport master (
    input  frame_valid_in, num_balls_in, model_x_in, model_y_in, real_x_in, real_y_in,
    input  eval_done_in, eval_error_in, eval_correct_in,
    output eval_rst_out, eval_valid_out, eval_num_balls_out,
    output eval_model_x_out, eval_model_y_out, eval_real_x_out, eval_real_y_out,
    output result_valid_out, result_error_out, result_correct_out,
    output streak_out, frames_evaluated_out, frames_dropped_out, timeout_out, busy_out
  );

  modport slave (
    output frame_valid_in, num_balls_in, model_x_in, model_y_in, real_x_in, real_y_in,
    output eval_done_in, eval_error_in, eval_correct_in,
    input  eval_rst_out, eval_valid_out, eval_num_balls_out,
    input  eval_model_x_out, eval_model_y_out, eval_real_x_out, eval_real_y_out,
    input  result_valid_out, result_error_out, result_correct_out,
    input  streak_out, frames_evaluated_out, frames_dropped_out, timeout_out, busy_out
  );

endinterface

// File: rtl/ball_frame_reg.sv
// Load-enabled holding register for one frame (ball count plus model/real coordinates).
// One cycle load-to-output; no flow control, holds until the next load.
module ball_frame_reg
  import juggle_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   load,
  input  frame_t d,
  output frame_t q
);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pattern_eval_scheduler.sv
// Runs the pattern evaluator once per frame: snapshot, reset, launch, wait (with timeout), report, session stats.
// Capture to launch 2 cycles, result 1 cycle after done; no backpressure, a one-deep pending slot absorbs and counts overwrites.
module pattern_eval_scheduler
  import juggle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_STREAK     = 255
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  pattern_eval_scheduler_if.master sched
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  // Counter value whose increment lands on TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [7:0]       STREAK_MAX = 8'(MAX_STREAK);

  sched_state_t state, next_state;

  frame_t in_frame, act_d, act_q, pend_q;
  logic   act_load, pend_load, pend_vld;

  logic [CNT_W-1:0]        wait_cnt;
  logic signed [ERR_W-1:0] res_err_d;
  logic                    res_corr_d;
  logic                    tmo_evt;

  assign in_frame.num_balls = sched.num_balls_in;
  assign in_frame.model_x   = sched.model_x_in;
  assign in_frame.model_y   = sched.model_y_in;
  assign in_frame.real_x    = sched.real_x_in;
  assign in_frame.real_y    = sched.real_y_in;

  // Only an IDLE with an empty pending slot captures straight into active.
  assign pend_load = sched.frame_valid_in && !(state == IDLE && !pend_vld);

  ball_frame_reg u_active (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load   (act_load),
    .d      (act_d),
    .q      (act_q)
  );

  ball_frame_reg u_pending (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load   (pend_load),
    .d      (in_frame),
    .q      (pend_q)
  );

  assign sched.eval_num_balls_out = act_q.num_balls;
  assign sched.eval_model_x_out   = act_q.model_x;
  assign sched.eval_model_y_out   = act_q.model_y;
  assign sched.eval_real_x_out    = act_q.real_x;
  assign sched.eval_real_y_out    = act_q.real_y;
  assign sched.eval_rst_out       = (state == CLEAR) || !rst_in;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    act_load   = 1'b0;
    act_d      = in_frame;
    res_err_d  = '0;
    res_corr_d = 1'b0;
    tmo_evt    = 1'b0;
    case (state)
      IDLE: begin
        if (pend_vld) begin
          act_load = 1'b1;
          act_d    = pend_q;
        end else if (sched.frame_valid_in) begin
          act_load = 1'b1;
        end
        if (act_load) begin
          if (act_d.num_balls == '0) begin
            next_state = REPORT;
            res_corr_d = 1'b1;
          end else begin
            next_state = CLEAR;
          end
        end
      end
      CLEAR:  next_state = LAUNCH;
      LAUNCH: next_state = WAIT;
      WAIT: begin
        if (sched.eval_done_in) begin
          next_state = REPORT;
          res_err_d  = sched.eval_error_in;
          res_corr_d = sched.eval_correct_in;
        end else if (wait_cnt == TMO_LAST) begin
          next_state = REPORT;
          res_err_d  = TIMEOUT_ERR;
          tmo_evt    = 1'b1;
        end
      end
      REPORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pend_vld                   <= 1'b0;
      wait_cnt                   <= '0;
      sched.eval_valid_out       <= 1'b0;
      sched.busy_out             <= 1'b0;
      sched.result_valid_out     <= 1'b0;
      sched.result_error_out     <= '0;
      sched.result_correct_out   <= 1'b0;
      sched.streak_out           <= '0;
      sched.frames_evaluated_out <= '0;
      sched.frames_dropped_out   <= '0;
      sched.timeout_out          <= 1'b0;
    end else begin
      if (state == IDLE && pend_vld) begin
        pend_vld <= sched.frame_valid_in;
      end else if (pend_load) begin
        pend_vld <= 1'b1;
      end

      if (pend_load && pend_vld && state != IDLE && sched.frames_dropped_out != 16'hFFFF) begin
        sched.frames_dropped_out <= sched.frames_dropped_out + 16'd1;
      end

      if (state == LAUNCH) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      sched.eval_valid_out   <= (next_state == LAUNCH);
      sched.busy_out         <= (next_state != IDLE);
      sched.result_valid_out <= (next_state == REPORT);

      if (next_state == REPORT) begin
        sched.result_error_out     <= res_err_d;
        sched.result_correct_out   <= res_corr_d;
        sched.frames_evaluated_out <= sched.frames_evaluated_out + 16'd1;
        if (!res_corr_d) begin
          sched.streak_out <= '0;
        end else if (sched.streak_out != STREAK_MAX) begin
          sched.streak_out <= sched.streak_out + 8'd1;
        end
      end

      if (tmo_evt) begin
        sched.timeout_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_eval_scheduler.sv
// Directed bench for pattern_eval_scheduler with a behavioural evaluator model driven on the falling edge.
// Cycle 0 is the IDLE cycle carrying the frame pulse; all checks sample at falling edges.
module tb_pattern_eval_scheduler;
  import juggle_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc;
  int   n_cmp = 0;
  int   n_bad = 0;

  bit                      m_en;
  int                      m_delay;
  int                      m_cnt;
  logic signed [ERR_W-1:0] m_err;
  logic                    m_corr;

  pattern_eval_scheduler_if sif ();

  pattern_eval_scheduler #(
    .TIMEOUT_CYCLES (4096),
    .MAX_STREAK     (255)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .sched  (sif)
  );

  always #5 clk = ~clk;

  // Evaluator model: done rises m_delay falling edges after the launch pulse and stays high until the next launch.
  initial begin
    sif.eval_done_in    = 1'b0;
    sif.eval_error_in   = '0;
    sif.eval_correct_in = 1'b0;
    m_cnt = -1;
    forever begin
      @(negedge clk);
      if (sif.eval_valid_out) begin
        sif.eval_done_in = 1'b0;
        m_cnt = m_en ? m_delay : -1;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          sif.eval_done_in    = 1'b1;
          sif.eval_error_in   = m_err;
          sif.eval_correct_in = m_corr;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic frame_t mk_frame(input logic [2:0] n, input int seed);
    frame_t f;
    f.num_balls = n;
    for (int i = 0; i < MAX_BALLS; i++) begin
      f.model_x[i] = X_W'(seed * 97 + i * 13);
      f.model_y[i] = Y_W'(seed * 53 + i * 7);
      f.real_x[i]  = f.model_x[i];
      f.real_y[i]  = f.model_y[i];
    end
    return f;
  endfunction

  function automatic frame_t snap();
    frame_t f;
    f.num_balls = sif.eval_num_balls_out;
    f.model_x   = sif.eval_model_x_out;
    f.model_y   = sif.eval_model_y_out;
    f.real_x    = sif.eval_real_x_out;
    f.real_y    = sif.eval_real_y_out;
    return f;
  endfunction

  task automatic send_frame(input frame_t f);
    sif.num_balls_in   = f.num_balls;
    sif.model_x_in     = f.model_x;
    sif.model_y_in     = f.model_y;
    sif.real_x_in      = f.real_x;
    sif.real_y_in      = f.real_y;
    sif.frame_valid_in = 1'b1;
    tick();
    sif.frame_valid_in = 1'b0;
  endtask

  task automatic wait_result(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (sif.result_valid_out) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (sif.eval_rst_out !== 1'b1) begin n_bad++; $display("FAIL rst_eval_rst: got %b want 1", sif.eval_rst_out); end
    n_cmp++; if (sif.busy_out !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", sif.busy_out); end
    n_cmp++; if (sif.eval_valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_eval_valid: got %b want 0", sif.eval_valid_out); end
    n_cmp++; if (sif.result_valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_result_valid: got %b want 0", sif.result_valid_out); end
    n_cmp++; if (sif.streak_out !== 8'd0) begin n_bad++; $display("FAIL rst_streak: got %0d want 0", sif.streak_out); end
    n_cmp++; if (sif.frames_evaluated_out !== 16'd0) begin n_bad++; $display("FAIL rst_evaluated: got %0d want 0", sif.frames_evaluated_out); end
    n_cmp++; if (sif.frames_dropped_out !== 16'd0) begin n_bad++; $display("FAIL rst_dropped: got %0d want 0", sif.frames_dropped_out); end
    n_cmp++; if (sif.timeout_out !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b want 0", sif.timeout_out); end
    n_cmp++; if (snap() !== frame_t'('0)) begin n_bad++; $display("FAIL rst_snapshot: got %h want 0", snap()); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (sif.eval_rst_out !== 1'b0) begin n_bad++; $display("FAIL rst_release_eval_rst: got %b want 0", sif.eval_rst_out); end
    tick();
  endtask

  task automatic test_single();
    int at;
    frame_t fa;
    fa = mk_frame(3'd3, 1);
    m_en = 1'b1; m_delay = 40; m_err = '0; m_corr = 1'b1;
    cyc = 0;
    send_frame(fa);
    n_cmp++; if (sif.eval_rst_out !== 1'b1) begin n_bad++; $display("FAIL single_rst_c1: got %b want 1", sif.eval_rst_out); end
    n_cmp++; if (sif.eval_valid_out !== 1'b0) begin n_bad++; $display("FAIL single_valid_c1: got %b want 0", sif.eval_valid_out); end
    n_cmp++; if (sif.busy_out !== 1'b1) begin n_bad++; $display("FAIL single_busy_c1: got %b want 1", sif.busy_out); end
    tick();
    n_cmp++; if (sif.eval_valid_out !== 1'b1) begin n_bad++; $display("FAIL single_valid_c2: got %b want 1", sif.eval_valid_out); end
    n_cmp++; if (sif.eval_rst_out !== 1'b0) begin n_bad++; $display("FAIL single_rst_c2: got %b want 0", sif.eval_rst_out); end
    n_cmp++; if (snap() !== fa) begin n_bad++; $display("FAIL single_snapshot: got %h want %h", snap(), fa); end
    wait_result(100, at);
    n_cmp++; if (at !== 43) begin n_bad++; $display("FAIL single_result_cycle: got %0d want 43", at); end
    n_cmp++; if (sif.result_error_out !== 15'sd0) begin n_bad++; $display("FAIL single_error: got %0d want 0", sif.result_error_out); end
    n_cmp++; if (sif.result_correct_out !== 1'b1) begin n_bad++; $display("FAIL single_correct: got %b want 1", sif.result_correct_out); end
    n_cmp++; if (sif.streak_out !== 8'd1) begin n_bad++; $display("FAIL single_streak: got %0d want 1", sif.streak_out); end
    n_cmp++; if (sif.frames_evaluated_out !== 16'd1) begin n_bad++; $display("FAIL single_evaluated: got %0d want 1", sif.frames_evaluated_out); end
    n_cmp++; if (snap() !== fa) begin n_bad++; $display("FAIL single_snapshot_report: got %h want %h", snap(), fa); end
    tick();
    n_cmp++; if (sif.result_valid_out !== 1'b0) begin n_bad++; $display("FAIL single_result_pulse: got %b want 0", sif.result_valid_out); end
    n_cmp++; if (sif.busy_out !== 1'b0) begin n_bad++; $display("FAIL single_busy_idle: got %b want 0", sif.busy_out); end
  endtask

  task automatic test_back_to_back();
    int at;
    frame_t fa, fb, fc;
    fa = mk_frame(3'd3, 1);
    fb = mk_frame(3'd2, 2);
    fc = mk_frame(3'd5, 3);
    m_en = 1'b1; m_delay = 40; m_err = '0; m_corr = 1'b1;
    cyc = 0;
    send_frame(fa);
    while (cyc < 10) tick();
    send_frame(fb);
    while (cyc < 20) tick();
    send_frame(fc);
    n_cmp++; if (snap() !== fa) begin n_bad++; $display("FAIL b2b_active_held: got %h want %h", snap(), fa); end
    wait_result(100, at);
    n_cmp++; if (at !== 43) begin n_bad++; $display("FAIL b2b_first_result: got %0d want 43", at); end
    n_cmp++; if (sif.frames_dropped_out !== 16'd1) begin n_bad++; $display("FAIL b2b_dropped: got %0d want 1", sif.frames_dropped_out); end
    tick();
    n_cmp++; if (sif.busy_out !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap: got %b want 0", sif.busy_out); end
    tick();
    n_cmp++; if (sif.eval_rst_out !== 1'b1) begin n_bad++; $display("FAIL b2b_clear_r2: got %b want 1", sif.eval_rst_out); end
    tick();
    n_cmp++; if (sif.eval_valid_out !== 1'b1) begin n_bad++; $display("FAIL b2b_launch_r3: got %b want 1", sif.eval_valid_out); end
    n_cmp++; if (snap() !== fc) begin n_bad++; $display("FAIL b2b_third_data: got %h want %h", snap(), fc); end
    wait_result(100, at);
    n_cmp++; if (at !== 87) begin n_bad++; $display("FAIL b2b_second_result: got %0d want 87", at); end
    n_cmp++; if (sif.frames_evaluated_out !== 16'd3) begin n_bad++; $display("FAIL b2b_evaluated: got %0d want 3", sif.frames_evaluated_out); end
    n_cmp++; if (sif.streak_out !== 8'd3) begin n_bad++; $display("FAIL b2b_streak: got %0d want 3", sif.streak_out); end
    tick();
  endtask

  task automatic test_timeout();
    int at;
    m_en = 1'b0;
    cyc = 0;
    send_frame(mk_frame(3'd4, 4));
    wait_result(5000, at);
    n_cmp++; if (at !== 4098) begin n_bad++; $display("FAIL tmo_cycle: got %0d want 4098", at); end
    n_cmp++; if (sif.result_error_out !== 15'sh3FFF) begin n_bad++; $display("FAIL tmo_error: got %h want 3fff", sif.result_error_out); end
    n_cmp++; if (sif.result_correct_out !== 1'b0) begin n_bad++; $display("FAIL tmo_correct: got %b want 0", sif.result_correct_out); end
    n_cmp++; if (sif.timeout_out !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b want 1", sif.timeout_out); end
    n_cmp++; if (sif.streak_out !== 8'd0) begin n_bad++; $display("FAIL tmo_streak: got %0d want 0", sif.streak_out); end
    tick();
  endtask

  task automatic test_zero_balls();
    cyc = 0;
    send_frame(mk_frame(3'd0, 5));
    n_cmp++; if (sif.result_valid_out !== 1'b1) begin n_bad++; $display("FAIL zero_result_c1: got %b want 1", sif.result_valid_out); end
    n_cmp++; if (sif.eval_rst_out !== 1'b0) begin n_bad++; $display("FAIL zero_no_rst: got %b want 0", sif.eval_rst_out); end
    n_cmp++; if (sif.eval_valid_out !== 1'b0) begin n_bad++; $display("FAIL zero_no_valid: got %b want 0", sif.eval_valid_out); end
    n_cmp++; if (sif.result_correct_out !== 1'b1) begin n_bad++; $display("FAIL zero_correct: got %b want 1", sif.result_correct_out); end
    n_cmp++; if (sif.result_error_out !== 15'sd0) begin n_bad++; $display("FAIL zero_error: got %0d want 0", sif.result_error_out); end
    n_cmp++; if (sif.timeout_out !== 1'b1) begin n_bad++; $display("FAIL zero_timeout_sticky: got %b want 1", sif.timeout_out); end
    n_cmp++; if (sif.streak_out !== 8'd1) begin n_bad++; $display("FAIL zero_streak: got %0d want 1", sif.streak_out); end
    tick();
    n_cmp++; if (sif.eval_valid_out !== 1'b0 || sif.eval_rst_out !== 1'b0) begin n_bad++; $display("FAIL zero_no_launch_c2: got valid=%b rst=%b want 0/0", sif.eval_valid_out, sif.eval_rst_out); end
  endtask

  task automatic test_streak();
    int at;
    int exp_s;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send_frame(mk_frame(3'd0, i));
      exp_s = (i + 1 > 255) ? 255 : i + 1;
      n_cmp++; if (sif.result_valid_out !== 1'b1 || sif.streak_out !== 8'(exp_s)) begin n_bad++; $display("FAIL streak_step%0d: got valid=%b streak=%0d want 1/%0d", i, sif.result_valid_out, sif.streak_out, exp_s); end
      tick();
    end
    n_cmp++; if (sif.streak_out !== 8'd255) begin n_bad++; $display("FAIL streak_saturated: got %0d want 255", sif.streak_out); end
    m_en = 1'b1; m_delay = 5; m_err = 15'sd123; m_corr = 1'b0;
    cyc = 0;
    send_frame(mk_frame(3'd3, 9));
    wait_result(100, at);
    n_cmp++; if (at !== 8) begin n_bad++; $display("FAIL streak_bad_cycle: got %0d want 8", at); end
    n_cmp++; if (sif.streak_out !== 8'd0) begin n_bad++; $display("FAIL streak_reset: got %0d want 0", sif.streak_out); end
    n_cmp++; if (sif.frames_evaluated_out !== 16'd257) begin n_bad++; $display("FAIL streak_evaluated: got %0d want 257", sif.frames_evaluated_out); end
    n_cmp++; if (sif.result_error_out !== 15'sd123 || sif.result_correct_out !== 1'b0) begin n_bad++; $display("FAIL streak_bad_result: got err=%0d corr=%b want 123/0", sif.result_error_out, sif.result_correct_out); end
    tick();
  endtask

  task automatic test_mid_wait_reset();
    bit saw_result, saw_busy, saw_launch;
    m_en = 1'b1; m_delay = 40; m_err = '0; m_corr = 1'b1;
    cyc = 0;
    send_frame(mk_frame(3'd3, 11));
    while (cyc < 5) tick();
    send_frame(mk_frame(3'd2, 12));
    tick();
    send_frame(mk_frame(3'd6, 13));
    while (cyc < 10) tick();
    n_cmp++; if (sif.frames_dropped_out !== 16'd1) begin n_bad++; $display("FAIL mwr_dropped_before: got %0d want 1", sif.frames_dropped_out); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sif.eval_rst_out !== 1'b1) begin n_bad++; $display("FAIL mwr_eval_rst: got %b want 1", sif.eval_rst_out); end
    tick();
    rst_n = 1'b1;
    n_cmp++; if (sif.busy_out !== 1'b0) begin n_bad++; $display("FAIL mwr_busy: got %b want 0", sif.busy_out); end
    n_cmp++; if (sif.frames_evaluated_out !== 16'd0) begin n_bad++; $display("FAIL mwr_evaluated: got %0d want 0", sif.frames_evaluated_out); end
    n_cmp++; if (sif.frames_dropped_out !== 16'd0) begin n_bad++; $display("FAIL mwr_dropped: got %0d want 0", sif.frames_dropped_out); end
    n_cmp++; if (snap() !== frame_t'('0)) begin n_bad++; $display("FAIL mwr_snapshot: got %h want 0", snap()); end
    n_cmp++; if (sif.eval_valid_out !== 1'b0 || sif.result_valid_out !== 1'b0) begin n_bad++; $display("FAIL mwr_pulses: got valid=%b result=%b want 0/0", sif.eval_valid_out, sif.result_valid_out); end
    saw_result = 1'b0; saw_busy = 1'b0; saw_launch = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (sif.result_valid_out) saw_result = 1'b1;
      if (sif.busy_out) saw_busy = 1'b1;
      if (sif.eval_valid_out || sif.eval_rst_out) saw_launch = 1'b1;
    end
    n_cmp++; if (saw_result !== 1'b0) begin n_bad++; $display("FAIL mwr_no_result: got %b want 0", saw_result); end
    n_cmp++; if (saw_busy !== 1'b0) begin n_bad++; $display("FAIL mwr_pending_cleared: got busy=%b want 0", saw_busy); end
    n_cmp++; if (saw_launch !== 1'b0) begin n_bad++; $display("FAIL mwr_no_launch: got %b want 0", saw_launch); end
  endtask

  initial begin
    rst_n              = 1'b0;
    cyc                = 0;
    m_en               = 1'b0;
    m_delay            = 1;
    m_err              = '0;
    m_corr             = 1'b0;
    sif.frame_valid_in = 1'b0;
    sif.num_balls_in   = '0;
    sif.model_x_in     = '0;
    sif.model_y_in     = '0;
    sif.real_x_in      = '0;
    sif.real_y_in      = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_zero_balls();
    test_streak();
    test_mid_wait_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
